led_event_blinker: RTL
======================

Name: led_event_blinker

Overview:
- Output-side counterpart of the key debounce path: turns single-cycle event pulses into blinks long enough to see on a board LED pin.
- Each accepted event produces exactly one ON window followed by a mandatory OFF gap.
- Events arriving while a blink is in progress are queued in a saturating pending counter.
- Sits between SoC/GPIO event logic and the LED pad.

Parameters:
CNT_W, 20, width of blink timer; ON_CYCLES and OFF_CYCLES must be < 2^CNT_W
ON_CYCLES, 1000000, LED active duration per blink in clk cycles (>=1)
OFF_CYCLES, 500000, mandatory inactive gap after each blink in clk cycles (>=1)
PEND_W, 4, pending-event counter width; max queued = 2^PEND_W-1
LED_ACTIVE_LOW, 0, 1 = led_out driven low when lit

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
evt_pulse  input  1  event request, sampled each rising clk edge; each high cycle = one event
clr  input  1  synchronous clear of pending count and overflow flag
led_out  output  1  LED drive, polarity per LED_ACTIVE_LOW
busy  output  1  high whenever state != IDLE
pending  output  PEND_W  number of queued events not yet started
ovf  output  1  sticky: an event was dropped due to full queue

Behaviour:
- Reset (async, rstn low): state=IDLE, timer=0, pending=0, ovf=0, busy=0, led_out=inactive level (0, or 1 if LED_ACTIVE_LOW). Takes effect immediately, including mid-blink; no blink resumes after release.
- All outputs registered.
- States: IDLE, ON, GAP.
- start = (state==IDLE | (state==GAP & timer==OFF_CYCLES-1)) & (pending!=0 | evt_pulse) & !clr.
- start -> state ON, timer=0, led lit next cycle. Latency evt_pulse sampled at edge N (queue empty, IDLE) -> led lit from edge N+1.
- ON: timer increments each cycle; at timer==ON_CYCLES-1 -> GAP, timer=0. LED lit exactly ON_CYCLES cycles.
- GAP: LED inactive; at timer==OFF_CYCLES-1 -> ON if start, else IDLE.
- Back-to-back blink period is exactly ON_CYCLES+OFF_CYCLES. No extra IDLE cycle between queued blinks.
- Pending update: next = pending + evt_pulse - (start & pending!=0). An evt_pulse consumed directly by start with pending==0 is not counted.
- Full queue: pending==2^PEND_W-1 and evt_pulse and the event is neither consumed nor offset by a decrement -> event dropped, pending holds, ovf<=1.
- Simultaneous evt and decrement at full: net pending unchanged, no overflow.
- clr: pending<=0, ovf<=0. evt_pulse in the same cycle is discarded. Suppresses start that cycle. Does not abort an ON/GAP in progress; timer unaffected.
- ovf stays set until clr or reset.
- Timer never wraps; its compares are exact equality against parameters.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2, LED_ACTIVE_LOW=0):
1. Single evt_pulse at edge 10 -> led_out=1 cycles 11-14, 0 from 15; busy=1 cycles 11-17, 0 at 18; pending stays 0.
2. evt_pulse high edges 10,11,12 -> pending peaks at 2. LED lit 11-14, 18-21, 25-28. busy continuous 11-31. pending back to 0 after edge 24.
3. evt_pulse high edges 10-14 (5 events) -> pending saturates at 3, ovf=1 at edge 15. Exactly 4 blinks observed; ovf remains 1 afterwards.
4. Fill pending to 3, assert clr at cycle 13 during first ON -> pending=0, ovf=0 at 14. First blink completes at 14, GAP 15-17, IDLE 18; no further blinks.
5. rstn low at cycle 12 mid-ON -> led_out=0, busy=0, pending=0 immediately without waiting for a clk edge. After release, no LED activity until a new evt_pulse.
6. LED_ACTIVE_LOW=1, repeat scenario 1 -> led_out=1 at reset and idle, 0 during cycles 11-14.

Source files
------------

// File: rtl/led_event_blinker.sv
// led_event_blinker: stretches single-cycle event pulses into visible LED blinks, queueing a saturating backlog.
module led_event_blinker #(
    parameter int CNT_W          = 20,
    parameter int ON_CYCLES      = 1000000,
    parameter int OFF_CYCLES     = 500000,
    parameter int PEND_W         = 4,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              evt_pulse,
    input  logic              clr,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);
    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic              LED_OFF  = LED_ACTIVE_LOW;
    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             start, inc, dec;
    assign start = (state == IDLE || (state == GAP && timer == OFF_LAST)) && (pending != '0 || evt_pulse) && !clr;
    // an event that coincides with a start either is consumed directly or offsets the dequeue
    assign inc = evt_pulse && !start;
    assign dec = start && !evt_pulse;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            timer   <= '0;
            pending <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            led_out <= LED_OFF;
        end else begin
            if (clr) begin
                pending <= '0;
                ovf     <= 1'b0;
            end else if (inc) begin
                if (pending == PEND_MAX) ovf <= 1'b1;
                else pending <= pending + PEND_W'(1);
            end else if (dec) begin
                pending <= pending - PEND_W'(1);
            end
            case (state)
                IDLE: if (start) begin
                    state   <= ON;
                    timer   <= '0;
                    busy    <= 1'b1;
                    led_out <= ~LED_OFF;
                end
                ON: if (timer == ON_LAST) begin
                    state   <= GAP;
                    timer   <= '0;
                    led_out <= LED_OFF;
                end else begin
                    timer <= timer + CNT_W'(1);
                end
                GAP: if (timer == OFF_LAST) begin
                    state   <= start ? ON : IDLE;
                    timer   <= '0;
                    busy    <= start;
                    led_out <= start ^ LED_OFF;
                end else begin
                    timer <= timer + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
